// File: rtl/alu_arb_pkg.sv
// Shared state encoding, port ids and default widths for the two-port ALU arbiter.
package alu_arb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CTRL_WIDTH = 3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way grant logic with round-robin pointer.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) and drops the pointer.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       take_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_clk_rst_take;
    assign unused_clk_rst_take = clk_i ^ rst_i ^ take_i;

    always_comb begin
        gnt_id_o = valid_i[0] ? PORT0 : PORT1;
    end
`else
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        if (valid_i == 2'b11) begin
            gnt_id_o = ptr_q;
        end else if (valid_i[0]) begin
            gnt_id_o = PORT0;
        end else begin
            gnt_id_o = PORT1;
        end
        ptr_d = ptr_q;
        // The loser of this grant is preferred next time.
        if (take_i) begin
            ptr_d = ~gnt_id_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt_o = (valid_i == 2'b00) ? 2'b00 :
                   (gnt_id_o == PORT1) ? 2'b10 : 2'b01;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters (IDLE/EXEC/RESP).
// Arbitration mode is set in alu_arb_rr via ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter #(
    parameter int DATA_WIDTH = alu_arb_pkg::DATA_WIDTH,
    parameter int CTRL_WIDTH = alu_arb_pkg::CTRL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            Req_valid,
    output logic [1:0]            Req_ready,
    input  logic [DATA_WIDTH-1:0] Req0_SrcA,
    input  logic [DATA_WIDTH-1:0] Req0_SrcB,
    input  logic [CTRL_WIDTH-1:0] Req0_ALUControl,
    input  logic [DATA_WIDTH-1:0] Req1_SrcA,
    input  logic [DATA_WIDTH-1:0] Req1_SrcB,
    input  logic [CTRL_WIDTH-1:0] Req1_ALUControl,
    output logic [1:0]            Rsp_valid,
    input  logic [1:0]            Rsp_ready,
    output logic [DATA_WIDTH-1:0] Rsp_ALUResult,
    output logic                  Rsp_Zero_flag,
    output logic [DATA_WIDTH-1:0] ALU_SrcA,
    output logic [DATA_WIDTH-1:0] ALU_SrcB,
    output logic [CTRL_WIDTH-1:0] ALU_ALUControl,
    input  logic [DATA_WIDTH-1:0] ALU_Result,
    input  logic                  ALU_Zero_flag,
    output logic                  Busy
);
    import alu_arb_pkg::*;

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] srca_q, srca_d;
    logic [DATA_WIDTH-1:0] srcb_q, srcb_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic [1:0]            rv_q, rv_d;
    logic [1:0]            gnt;
    logic                  gnt_id;
    logic                  req_hs;

    alu_arb_rr u_rr (
        .clk_i    (CLK),
        .rst_i    (RST),
        .valid_i  (Req_valid),
        .take_i   (req_hs),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign Req_ready = (state_q == IDLE && !RST) ? gnt : 2'b00;
    assign req_hs    = |(Req_valid & Req_ready);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        rv_d    = rv_q;
        unique case (state_q)
            IDLE: begin
                if (req_hs) begin
                    srca_d  = (gnt_id == PORT1) ? Req1_SrcA : Req0_SrcA;
                    srcb_d  = (gnt_id == PORT1) ? Req1_SrcB : Req0_SrcB;
                    ctrl_d  = (gnt_id == PORT1) ? Req1_ALUControl
                                                : Req0_ALUControl;
                    gnt_d   = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = ALU_Result;
                zero_d  = ALU_Zero_flag;
                rv_d    = (gnt_q == PORT1) ? 2'b10 : 2'b01;
                state_d = RESP;
            end
            RESP: begin
                if (Rsp_ready[gnt_q]) begin
                    rv_d    = 2'b00;
                    state_d = IDLE;
                end
            end
            default: begin
                rv_d    = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= PORT0;
            srca_q  <= '0;
            srcb_q  <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            rv_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            rv_q    <= rv_d;
        end
    end

    assign Rsp_valid      = RST ? 2'b00 : rv_q;
    assign Rsp_ALUResult  = res_q;
    assign Rsp_Zero_flag  = zero_q;
    assign ALU_SrcA       = srca_q;
    assign ALU_SrcB       = srcb_q;
    assign ALU_ALUControl = ctrl_q;
    assign Busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model.
// Also builds with ALU_ARB_FIXED_PRIO_EN for fixed-priority expectations.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    Req_valid, Req_ready, Rsp_valid, Rsp_ready;
    logic [DW-1:0] Req0_SrcA, Req0_SrcB, Req1_SrcA, Req1_SrcB;
    logic [CW-1:0] Req0_ALUControl, Req1_ALUControl;
    logic [DW-1:0] Rsp_ALUResult, ALU_SrcA, ALU_SrcB, ALU_Result;
    logic [CW-1:0] ALU_ALUControl;
    logic          Rsp_Zero_flag, ALU_Zero_flag, Busy;

    alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST),
        .Req_valid(Req_valid), .Req_ready(Req_ready),
        .Req0_SrcA(Req0_SrcA), .Req0_SrcB(Req0_SrcB),
        .Req0_ALUControl(Req0_ALUControl),
        .Req1_SrcA(Req1_SrcA), .Req1_SrcB(Req1_SrcB),
        .Req1_ALUControl(Req1_ALUControl),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready),
        .Rsp_ALUResult(Rsp_ALUResult), .Rsp_Zero_flag(Rsp_Zero_flag),
        .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB),
        .ALU_ALUControl(ALU_ALUControl),
        .ALU_Result(ALU_Result), .ALU_Zero_flag(ALU_Zero_flag),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [CW-1:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ b;
            3'b100:  return a - b;
            3'b101:  return {31'd0, $signed(a) < $signed(b)};
            3'b110:  return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Shared ALU stand-in
    assign ALU_Result    = alu_f(ALU_SrcA, ALU_SrcB, ALU_ALUControl);
    assign ALU_Zero_flag = (ALU_Result == '0);

    // Transaction-level model: one op in flight, age 0 = executing, 1 = responding
    int            m_ptr, m_age, m_gid;
    bit            m_active;
    logic [DW-1:0] m_a, m_b, m_res;
    logic [CW-1:0] m_op;
    logic          m_zero;

    int vectors = 0;
    int miscompares = 0;
    int checks = 0;
    int cyc = 0;

    int            gq_port[$], gq_cyc[$], rq_port[$], rq_cyc[$];
    logic [DW-1:0] rq_res[$];
    logic          rq_zero[$];

    function automatic int pick(input logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return v[0] ? 0 : 1;
`else
        if (v == 2'b11) return m_ptr;
        return v[0] ? 0 : 1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic clearq();
        gq_port.delete(); gq_cyc.delete();
        rq_port.delete(); rq_cyc.delete();
        rq_res.delete();  rq_zero.delete();
    endtask

    // Inputs are set at the negedge before calling; compare, clock, update model.
    task automatic cycle();
        logic [1:0] exp_rdy, exp_rv;
        int w;
        #1;
        w = pick(Req_valid);
        exp_rdy = (!RST && !m_active && |Req_valid) ? (2'b01 << w) : 2'b00;
        exp_rv  = (!RST && m_active && m_age == 1) ? (2'b01 << m_gid) : 2'b00;
        chk("req_ready", Req_ready, exp_rdy);
        chk("rsp_valid", Rsp_valid, exp_rv);
        chk("rsp_result", Rsp_ALUResult, m_res);
        chk("rsp_zero", Rsp_Zero_flag, m_zero);
        chk("alu_srca", ALU_SrcA, m_a);
        chk("alu_srcb", ALU_SrcB, m_b);
        chk("alu_ctrl", ALU_ALUControl, m_op);
        chk("busy", Busy, m_active);
        if (|(Req_valid & Req_ready)) begin
            gq_port.push_back(int'(Req_ready[1]));
            gq_cyc.push_back(cyc);
        end
        if (|(Rsp_valid & Rsp_ready)) begin
            rq_port.push_back(int'(Rsp_valid[1]));
            rq_cyc.push_back(cyc);
            rq_res.push_back(Rsp_ALUResult);
            rq_zero.push_back(Rsp_Zero_flag);
        end
        @(posedge CLK);
        if (RST) begin
            m_active = 0; m_ptr = 0; m_age = 0; m_gid = 0;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 1'b0;
        end else if (!m_active) begin
            if (|Req_valid) begin
                w = pick(Req_valid);
                m_a  = w ? Req1_SrcA : Req0_SrcA;
                m_b  = w ? Req1_SrcB : Req0_SrcB;
                m_op = w ? Req1_ALUControl : Req0_ALUControl;
                m_gid = w; m_age = 0; m_active = 1;
                m_ptr = 1 - w;
            end
        end else if (m_age == 0) begin
            m_res  = alu_f(m_a, m_b, m_op);
            m_zero = (m_res == '0);
            m_age  = 1;
        end else if (Rsp_ready[m_gid]) begin
            m_active = 0;
        end
        cyc++;
        vectors++;
        @(negedge CLK);
    endtask

    initial begin
        int exp_p1;
        RST = 1'b1; Req_valid = 2'b00; Rsp_ready = 2'b00;
        Req0_SrcA = '0; Req0_SrcB = '0; Req0_ALUControl = '0;
        Req1_SrcA = '0; Req1_SrcB = '0; Req1_ALUControl = '0;
        m_active = 0; m_ptr = 0; m_age = 0; m_gid = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 1'b0;
        @(negedge CLK);
        cycle(); cycle();
        RST = 1'b0;
        #1;
        chk("rst_req_ready", Req_ready, 2'b00);
        chk("rst_rsp_valid", Rsp_valid, 2'b00);
        chk("rst_result", Rsp_ALUResult, 0);
        chk("rst_zero", Rsp_Zero_flag, 0);
        chk("rst_srca", ALU_SrcA, 0);
        chk("rst_srcb", ALU_SrcB, 0);
        chk("rst_ctrl", ALU_ALUControl, 0);
        chk("rst_busy", Busy, 0);

        // Single add on port 0
        clearq();
        Rsp_ready = 2'b11;
        Req0_SrcA = 5; Req0_SrcB = 7; Req0_ALUControl = 3'b010;
        Req_valid = 2'b01;
        #1 chk("add_ready_same_cycle", Req_ready, 2'b01);
        cycle();
        Req_valid = 2'b00;
        repeat (3) cycle();
        chk("add_rsp_count", rq_res.size(), 1);
        chk("add_result", rq_res[0], 12);
        chk("add_zero", rq_zero[0], 0);
        chk("add_port", rq_port[0], 0);
        chk("add_latency", rq_cyc[0] - gq_cyc[0], 2);

        // Simultaneous requests from a fresh pointer
        RST = 1'b1; cycle(); RST = 1'b0;
        clearq();
        Req0_SrcA = 9; Req0_SrcB = 9; Req0_ALUControl = 3'b100;
        Req1_SrcA = 3; Req1_SrcB = 4; Req1_ALUControl = 3'b000;
        Req_valid = 2'b11; Rsp_ready = 2'b11;
        repeat (9) cycle();
        Req_valid = 2'b00;
        repeat (3) cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_p1 = 0;
`else
        exp_p1 = 1;
`endif
        chk("both_grant_count", gq_port.size(), 3);
        chk("both_grant0", gq_port[0], 0);
        chk("both_grant1", gq_port[1], exp_p1);
        chk("both_grant2", gq_port[2], 0);
        chk("both_rsp0_result", rq_res[0], 0);
        chk("both_rsp0_zero", rq_zero[0], 1);
        chk("both_rsp1_result", rq_res[1], 0);
        chk("both_rsp1_zero", rq_zero[1], 1);

        // Backpressure on port 1 while port 0 waits
        clearq();
        Req1_SrcA = 100; Req1_SrcB = 23; Req1_ALUControl = 3'b010;
        Req0_SrcA = 40; Req0_SrcB = 2; Req0_ALUControl = 3'b001;
        Req_valid = 2'b10; Rsp_ready = 2'b01;
        cycle();
        Req_valid = 2'b01;
        repeat (6) cycle();
        Rsp_ready = 2'b11;
        cycle();
        cycle();
        Req_valid = 2'b00;
        repeat (3) cycle();
        chk("bp_grant_count", gq_port.size(), 2);
        chk("bp_first_port", gq_port[0], 1);
        chk("bp_result", rq_res[0], 123);
        chk("bp_rsp_cycle", rq_cyc[0] - gq_cyc[0], 7);
        chk("bp_regrant_gap", gq_cyc[1] - rq_cyc[0], 1);
        chk("bp_second_port", gq_port[1], 0);
        chk("bp_second_result", rq_res[1], 42);

        // Reset while responding on port 0
        clearq();
        Rsp_ready = 2'b00;
        Req0_SrcA = 1; Req0_SrcB = 1; Req0_ALUControl = 3'b100;
        Req_valid = 2'b01;
        cycle();
        Req_valid = 2'b00;
        cycle();
        #1 chk("rr_rsp_pending", Rsp_valid, 2'b01);
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        #1;
        chk("rr_rsp_cleared", Rsp_valid, 2'b00);
        chk("rr_busy_cleared", Busy, 0);
        clearq();
        Req_valid = 2'b11; Rsp_ready = 2'b11;
        cycle();
        Req_valid = 2'b00;
        repeat (3) cycle();
        chk("rr_grant_count", gq_port.size(), 1);
        chk("rr_ptr_port0", gq_port[0], 0);
        chk("rr_no_stale_rsp", rq_res.size(), 1);

        // Back-to-back throughput on port 1
        clearq();
        Req_valid = 2'b10; Rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            Req1_SrcA = $urandom;
            Req1_SrcB = $urandom;
            Req1_ALUControl = CW'($urandom_range(0, 7));
            cycle();
        end
        Req_valid = 2'b00;
        repeat (3) cycle();
        chk("tp_rsp_count", rq_cyc.size(), 4);
        for (int i = 0; i < 3; i++) begin
            chk("tp_spacing", rq_cyc[i + 1] - rq_cyc[i], 3);
        end

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            Req_valid = 2'($urandom_range(0, 3));
            Rsp_ready = 2'($urandom_range(0, 3));
            Req0_SrcA = $urandom;
            Req0_SrcB = ($urandom_range(0, 3) == 0) ? Req0_SrcA : $urandom;
            Req0_ALUControl = CW'($urandom_range(0, 7));
            Req1_SrcA = $urandom_range(0, 15);
            Req1_SrcB = $urandom_range(0, 15);
            Req1_ALUControl = CW'($urandom_range(0, 7));
            RST = ($urandom_range(0, 63) == 0);
            cycle();
        end
        RST = 1'b0; Req_valid = 2'b00; Rsp_ready = 2'b11;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
